// File: rtl/spmm_pkg.sv
// Shared sizing constants, element type and FSM encoding for the sparse-matrix scheduler.
package spmm_pkg;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int LANES = 4;
  localparam int IDXW  = $clog2(N);
  localparam int PTRW  = 2 * IDXW;

  typedef logic [W-1:0] data_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Width of the pass index; a single lane still needs one bit to hold index 0.
  function automatic int kWidth(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/spmm_sched_if.sv
// Bundles the lhs/rhs/output handshakes and the PE side-channel of the scheduler.
interface spmm_sched_if #(
  parameter int N     = spmm_pkg::N,
  parameter int W     = spmm_pkg::W,
  parameter int LANES = spmm_pkg::LANES
);
  localparam int IDXW = $clog2(N);
  localparam int PTRW = 2 * IDXW;

  logic                            lhs_start;
  logic                            lhs_ws;
  logic                            lhs_os;
  logic [N-1:0][PTRW-1:0]          lhs_ptr;
  logic [N-1:0][IDXW-1:0]          lhs_col;
  logic [N-1:0][W-1:0]             lhs_data;
  logic                            lhs_ready_ns;
  logic                            lhs_ready_ws;
  logic                            lhs_ready_os;
  logic                            lhs_ready_wos;
  logic                            rhs_start;
  logic [LANES-1:0][N-1:0][W-1:0]  rhs_data;
  logic                            rhs_ready;
  logic                            out_start;
  logic                            out_ready;
  logic [LANES-1:0][N-1:0][W-1:0]  out_data;
  logic [31:0]                     pe_delay;
  logic                            pe_start;
  logic [N-1:0][PTRW-1:0]          pe_lhs_ptr;
  logic [N-1:0][IDXW-1:0]          pe_lhs_col;
  logic [N-1:0][W-1:0]             pe_lhs_data;
  logic [N-1:0][W-1:0]             pe_rhs;
  logic [N-1:0][W-1:0]             pe_out;
  logic                            busy;

  modport master (
    output lhs_start, lhs_ws, lhs_os, lhs_ptr, lhs_col, lhs_data,
    output rhs_start, rhs_data, out_start, pe_delay, pe_out,
    input  lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos,
    input  rhs_ready, out_ready, out_data, pe_start,
    input  pe_lhs_ptr, pe_lhs_col, pe_lhs_data, pe_rhs, busy
  );

  modport slave (
    input  lhs_start, lhs_ws, lhs_os, lhs_ptr, lhs_col, lhs_data,
    input  rhs_start, rhs_data, out_start, pe_delay, pe_out,
    output lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos,
    output rhs_ready, out_ready, out_data, pe_start,
    output pe_lhs_ptr, pe_lhs_col, pe_lhs_data, pe_rhs, busy
  );

endinterface

// File: rtl/spmm_acc_buf.sv
// Output tile buffer: each capture either overwrites or accumulates one lane column.
module spmm_acc_buf #(
  parameter int N          = spmm_pkg::N,
  parameter int W          = spmm_pkg::W,
  parameter int LANES      = spmm_pkg::LANES,
  localparam int KW        = spmm_pkg::kWidth(LANES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            i_capture,
  input  logic                            i_os,
  input  logic [KW-1:0]                   i_k,
  input  logic [N-1:0][W-1:0]             i_peOut,
  output logic [LANES-1:0][N-1:0][W-1:0]  o_buf
);
  import spmm_pkg::*;

  logic [LANES-1:0][N-1:0][W-1:0] r_buf;

  // Store the PE result into lane k, adding to the held value (wrapping at W bits) in os mode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf <= '0;
    end else if (i_capture) begin
      for (int e = 0; e < N; e++) begin
        r_buf[i_k][e] <= i_os ? (r_buf[i_k][e] + i_peOut[e]) : i_peOut[e];
      end
    end
  end

  assign o_buf = r_buf;

endmodule

// File: rtl/spmm_sched.sv
// Scheduler for one sparse lhs against LANES rhs columns: issues one PE pass per column.
module spmm_sched #(
  parameter int N          = spmm_pkg::N,
  parameter int W          = spmm_pkg::W,
  parameter int LANES      = spmm_pkg::LANES
) (
  input  logic         clock,
  input  logic         reset,
  spmm_sched_if.slave  bus
);
  import spmm_pkg::*;

  localparam int            KW     = kWidth(LANES);
  localparam int            CIW    = $clog2(N);
  localparam int            CPW    = 2 * CIW;
  localparam logic [KW-1:0] LAST_K = KW'(LANES - 1);

  logic [1:0]                     r_state;
  logic [KW-1:0]                  r_k;
  logic                           r_rhsValid;
  logic                           r_outValid;
  logic                           r_ws;
  logic                           r_os;
  logic [7:0]                     r_dly;
  logic [7:0]                     r_cnt;
  logic [N-1:0][CPW-1:0]          r_lhsPtr;
  logic [N-1:0][CIW-1:0]          r_lhsCol;
  logic [N-1:0][W-1:0]            r_lhsData;
  logic [LANES-1:0][N-1:0][W-1:0] r_rhs;

  logic                           w_idle;
  logic                           w_readyNs;
  logic                           w_readyOs;
  logic                           w_lhsAccept;
  logic                           w_rhsAccept;
  logic                           w_outAccept;
  logic                           w_capture;
  logic                           w_unusedDelay;
  logic [LANES-1:0][N-1:0][W-1:0] w_outBuf;

  // Every ready is decoded from registered state, so same-cycle offers see pre-edge values.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_readyNs   = w_idle & r_rhsValid & ~r_outValid;
  assign w_readyOs   = w_idle & r_rhsValid & r_outValid;
  assign w_lhsAccept = bus.lhs_start & (bus.lhs_os ? w_readyOs : w_readyNs);
  assign w_rhsAccept = bus.rhs_start & w_idle & ~r_rhsValid;
  assign w_outAccept = bus.out_start & w_idle & r_outValid;
  assign w_capture   = ((r_state == ST_ISSUE) && (r_dly == 8'd0)) ||
                       ((r_state == ST_WAIT) && (r_cnt == 8'd1));
  assign w_unusedDelay = ^bus.pe_delay[31:8];

  // Job FSM: accept in IDLE, one ISSUE cycle per pass, WAIT out the PE latency, advance on capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_rhsValid <= 1'b0;
      r_outValid <= 1'b0;
      r_ws       <= 1'b0;
      r_os       <= 1'b0;
      r_dly      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rhsAccept) r_rhsValid <= 1'b1;
          if (w_outAccept) r_outValid <= 1'b0;
          if (w_lhsAccept) begin
            r_ws    <= bus.lhs_ws;
            r_os    <= bus.lhs_os;
            r_dly   <= bus.pe_delay[7:0];
            r_k     <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt <= r_dly;
          if (r_dly != 8'd0) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_capture) begin
        if (r_k == LAST_K) begin
          r_state    <= ST_IDLE;
          r_outValid <= 1'b1;
          if (!r_ws) r_rhsValid <= 1'b0;
        end else begin
          r_k     <= r_k + KW'(1);
          r_state <= ST_ISSUE;
        end
      end
    end
  end

  // Operand latches: rhs tile on rhs acceptance, lhs CSR arrays held stable between lhs acceptances.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rhs     <= '0;
      r_lhsPtr  <= '0;
      r_lhsCol  <= '0;
      r_lhsData <= '0;
    end else begin
      if (w_rhsAccept) r_rhs <= bus.rhs_data;
      if (w_lhsAccept) begin
        r_lhsPtr  <= bus.lhs_ptr;
        r_lhsCol  <= bus.lhs_col;
        r_lhsData <= bus.lhs_data;
      end
    end
  end

  spmm_acc_buf #(.N(N), .W(W), .LANES(LANES)) u_accBuf (
    .clock     (clock),
    .reset     (reset),
    .i_capture (w_capture),
    .i_os      (r_os),
    .i_k       (r_k),
    .i_peOut   (bus.pe_out),
    .o_buf     (w_outBuf)
  );

  assign bus.rhs_ready     = w_idle & ~r_rhsValid;
  assign bus.lhs_ready_ns  = w_readyNs;
  assign bus.lhs_ready_ws  = w_readyNs;
  assign bus.lhs_ready_os  = w_readyOs;
  assign bus.lhs_ready_wos = w_readyOs;
  assign bus.out_ready     = r_outValid;
  assign bus.out_data      = w_outBuf;
  assign bus.busy          = ~w_idle;
  assign bus.pe_start      = (r_state == ST_ISSUE);
  assign bus.pe_rhs        = r_rhs[r_k];
  assign bus.pe_lhs_ptr    = r_lhsPtr;
  assign bus.pe_lhs_col    = r_lhsCol;
  assign bus.pe_lhs_data   = r_lhsData;

endmodule

// File: doc/spmm_sched.md
SPMM_SCHED -- requirements
Module: spmm_sched

Interface
REQ-001 SHALL have parameters: N, default 16, vector length; W, default 8, element width; LANES, default 4, rhs columns per job.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low
- lhs_start  in  1  lhs job offer
- lhs_ws  in  1  keep rhs after job
- lhs_os  in  1  accumulate into held output
- lhs_ptr  in  N x 2*clog2(N)  CSR row pointers
- lhs_col  in  N x clog2(N)  column indices
- lhs_data  in  N x W  nonzeros
- lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos  out  1 each  per-mode acceptance
- rhs_start  in  1  rhs offer
- rhs_data  in  LANES x N x W  rhs tile
- rhs_ready  out  1  rhs buffer free
- out_start  in  1  output consumed
- out_ready  out  1  output buffer valid
- out_data  out  LANES x N x W  output buffer
- pe_delay  in  32  PE latency, bits [7:0] used
- pe_start  out  1  pass start pulse to PE
- pe_lhs_ptr, pe_lhs_col, pe_lhs_data  out  as lhs  latched lhs to PE
- pe_rhs  out  N x W  current rhs column
- pe_out  in  N x W  PE result
- busy  out  1  job in progress

Function
REQ-004 State: IDLE, ISSUE, WAIT; pass index k (0..LANES-1); flags rhs_valid, out_valid; latched ws_l, os_l, dly_l.
REQ-005 rhs_ready SHALL = (state==IDLE) & !rhs_valid; rhs_start while rhs_ready latches rhs_data and sets rhs_valid; otherwise ignored.
REQ-006 lhs_ready_ns and lhs_ready_ws SHALL = IDLE & rhs_valid & !out_valid; lhs_ready_os and lhs_ready_wos SHALL = IDLE & rhs_valid & out_valid.
REQ-007 lhs_start SHALL be accepted only when the ready matching {lhs_ws,lhs_os} is high; on acceptance latch lhs_*, ws_l, os_l, dly_l=pe_delay[7:0], k=0, go ISSUE; otherwise ignore.
REQ-008 ISSUE: pe_start=1 for exactly one cycle, pe_rhs=rhs column k; counter loaded with dly_l; if dly_l==0 capture at end of this cycle, else go WAIT.
REQ-009 WAIT: decrement counter; capture at the edge where it reaches 0.
REQ-010 Capture: out_buf[k] = os_l ? out_buf[k]+pe_out : pe_out, per element modulo 2^W; if k<LANES-1, k++ and ISSUE; else go IDLE, set out_valid, clear rhs_valid unless ws_l.
REQ-011 Latency: lhs accepted in cycle c0 -> out_ready first high in cycle c0 + LANES*(dly_l+1) + 1.
REQ-012 out_ready SHALL = out_valid; out_data SHALL always drive out_buf; out_start while out_ready clears out_valid next edge; ignored otherwise.
REQ-013 All readies SHALL be decoded from registers only, using pre-edge values: simultaneous out_start+lhs_start does not accept an ns job that cycle; simultaneous rhs_start+lhs_start with rhs_valid=0 accepts rhs only.
REQ-014 rhs_start, lhs_start, out_start while busy SHALL have no effect; busy SHALL = (state!=IDLE).
REQ-015 pe_lhs_* SHALL stay stable from acceptance until next acceptance.

Reset
REQ-016 reset low SHALL asynchronously force IDLE, k=0, rhs_valid=out_valid=0, pe_start=0, out_buf=0, all lhs/rhs latches=0, mid-job included; all readies except rhs_ready read 0 after reset.

Structure
REQ-017 N, W, LANES, clog2-derived widths and data_t (packed W-bit data) SHALL live in shared package spmm_pkg.
REQ-018 Output buffer with accumulate/clear SHALL be sub-module spmm_acc_buf; FSM and handshakes stay in spmm_sched.

Verification
REQ-019 Reset then rhs_start with tile 1s, lhs ns, pe_out=3s, pe_delay=0 -> 4 pe_start pulses in c1..c4, out_ready in c5, out_data all 3.
REQ-020 Same with pe_delay=2 -> pe_start spacing 3 cycles, out_ready at c0+13.
REQ-021 ns job out=5s, no drain, os job pe_out=250 -> out_data (255) mod 256 = 255; second os pe_out=2 -> 1 (wrap).
REQ-022 ws job -> rhs_ready stays 0 after completion, second lhs accepted without rhs_start; ns job -> rhs_ready 1 after completion.
REQ-023 out_start with lhs_start ns same cycle -> lhs ignored, accepted next cycle; rhs_start during busy -> ignored, rhs unchanged.
REQ-024 reset low in WAIT of pass 2 -> busy, pe_start, out_ready 0 immediately; out_data all 0.
